// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - parametrised sequential shift-add multiplier with start/busy/done handshake
// Operates on operand magnitudes, then applies the sign on the final iteration.

module seq_mul #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               smode_q, smode_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc_sum, prod;
    logic [WIDTH:0]     prod_hi_s;
    logic               prod_ovf;

    // -2^(W-1) negates to itself, which is exactly its magnitude read unsigned.
    always_comb begin
        mag_a = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
        mag_b = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
    end

    always_comb begin
        acc_sum   = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
        prod      = neg_q ? -acc_sum : acc_sum;
        prod_hi_s = prod[2*WIDTH-1:WIDTH-1];
        if (smode_q) begin
            prod_ovf = !((&prod_hi_s) || !(|prod_hi_s));
        end else begin
            prod_ovf = |prod[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        smode_d  = smode_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = S_DONE;
                    result_d = prod;
                    ovf_d    = prod_ovf;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // IDLE and DONE both accept a new request.
        if (start && state_q != S_RUN) begin
            state_d  = S_RUN;
            acc_d    = {2*WIDTH{1'b0}};
            mcand_d  = {{WIDTH{1'b0}}, mag_b};
            mplier_d = mag_a;
            cnt_d    = {CNT_W{1'b0}};
            neg_d    = signed_mode && (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
            smode_d  = signed_mode;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            smode_q  <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            smode_q  <= smode_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - self-checking bench for seq_mul (WIDTH=8 and WIDTH=16 instances)

module tb_seq_mul;

    logic        clock;
    logic        resetn;
    logic        start;
    logic        signed_mode;
    logic [7:0]  multiplier;
    logic [7:0]  multiplicand;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;

    logic        start16;
    logic        signed_mode16;
    logic [15:0] multiplier16;
    logic [15:0] multiplicand16;
    logic        busy16;
    logic        done16;
    logic [31:0] result16;
    logic        ovf16;

    int n_checks = 0;
    int n_fail   = 0;

    seq_mul #(.WIDTH(8)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .ovf          (ovf)
    );

    seq_mul #(.WIDTH(16)) dut16 (
        .clock        (clock),
        .resetn       (resetn),
        .start        (start16),
        .signed_mode  (signed_mode16),
        .multiplier   (multiplier16),
        .multiplicand (multiplicand16),
        .busy         (busy16),
        .done         (done16),
        .result       (result16),
        .ovf          (ovf16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp_res;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-number product, truncated, with range test against WIDTH=8.
    function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int  p;
        logic ov;
        if (s) begin
            p  = int'($signed(a)) * int'($signed(b));
            ov = (p > 127) || (p < -128);
        end else begin
            p  = int'({24'b0, a}) * int'({24'b0, b});
            ov = (p > 255);
        end
        return {ov, p[15:0]};
    endfunction

    // Call at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [15:0] res, output logic ov,
                         output int lat, output int busy_n);
        multiplier   = a;
        multiplicand = b;
        signed_mode  = s;
        start        = 1'b1;
        @(negedge clock);
        start        = 1'b0;
        multiplier   = 8'($urandom);
        multiplicand = 8'($urandom);
        signed_mode  = 1'($urandom);
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(negedge clock);
            lat++;
        end
        res = result;
        ov  = ovf;
        check("done_seen", {63'b0, done}, 64'd1);
        @(negedge clock);
        check("done_one_cycle", {63'b0, done}, 64'd0);
    endtask

    vec_t        vecs[10];
    logic [15:0] r;
    logic        o;
    logic [16:0] m;
    int          lat, busy_n, n, pulses, first_done, second_done;

    initial begin
        vecs[0] = '{8'd7,   8'd8,   1'b0, 16'd56,   1'b0};
        vecs[1] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01, 1'b1};
        vecs[2] = '{8'hFD,  8'd5,   1'b1, 16'hFFF1, 1'b0};
        vecs[3] = '{8'h80,  8'h80,  1'b1, 16'h4000, 1'b1};
        vecs[4] = '{8'h00,  8'hFF,  1'b1, 16'h0000, 1'b0};
        vecs[5] = '{8'h7F,  8'h7F,  1'b1, 16'h3F01, 1'b1};
        vecs[6] = '{8'hFF,  8'h01,  1'b1, 16'hFFFF, 1'b0};
        vecs[7] = '{8'h10,  8'h10,  1'b0, 16'h0100, 1'b1};
        vecs[8] = '{8'h0F,  8'h11,  1'b0, 16'h00FF, 1'b0};
        vecs[9] = '{8'h80,  8'h01,  1'b1, 16'hFF80, 1'b0};

        resetn = 1'b0; start = 1'b0; signed_mode = 1'b0; multiplier = '0; multiplicand = '0;
        start16 = 1'b0; signed_mode16 = 1'b0; multiplier16 = '0; multiplicand16 = '0;
        repeat (3) @(negedge clock);
        check("reset_busy",   {63'b0, busy},   64'd0);
        check("reset_done",   {63'b0, done},   64'd0);
        check("reset_result", {48'b0, result}, 64'd0);
        check("reset_ovf",    {63'b0, ovf},    64'd0);
        resetn = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, r, o, lat, busy_n);
            check($sformatf("vec%0d_result", i), {48'b0, r}, {48'b0, vecs[i].exp_res});
            check($sformatf("vec%0d_ovf", i),    {63'b0, o}, {63'b0, vecs[i].exp_ovf});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
            check($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'd8);
        end

        // Result holds in IDLE.
        repeat (4) @(negedge clock);
        check("idle_hold_result", {48'b0, result}, 64'h0080 ^ 64'hFF00);

        // start re-pulsed in the 3rd RUN cycle is ignored.
        multiplier = 8'd7; multiplicand = 8'd8; signed_mode = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0; pulses = 0; first_done = -1;
        while (n < 30) begin
            if (n == 2) begin
                start = 1'b1; multiplier = 8'd200; multiplicand = 8'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++;
                if (first_done < 0) first_done = n;
                check("ignore_result", {48'b0, result}, 64'd56);
            end
            @(negedge clock);
            n++;
        end
        check("ignore_pulses", 64'(pulses), 64'd1);
        check("ignore_done_at", 64'(first_done), 64'd8);

        // Reset during the 5th RUN cycle discards the operation.
        multiplier = 8'd9; multiplicand = 8'd9; signed_mode = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        check("rst_mid_busy",   {63'b0, busy},   64'd0);
        check("rst_mid_done",   {63'b0, done},   64'd0);
        check("rst_mid_result", {48'b0, result}, 64'd0);
        resetn = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("rst_mid_no_done", 64'(pulses), 64'd0);

        // start held high: back-to-back accept from DONE.
        multiplier = 8'd3; multiplicand = 8'd4; signed_mode = 1'b0; start = 1'b1;
        @(negedge clock);
        n = 0; first_done = -1; second_done = -1;
        while (n < 40 && second_done < 0) begin
            if (n == 2) begin
                multiplier = 8'd6; multiplicand = 8'd7;
            end
            if (done) begin
                if (first_done < 0) begin
                    first_done = n;
                    check("b2b_first_result", {48'b0, result}, 64'd12);
                end else begin
                    second_done = n;
                    check("b2b_second_result", {48'b0, result}, 64'd42);
                end
            end
            if (first_done >= 0 && n == first_done + 4)
                check("b2b_hold_during_run", {48'b0, result}, 64'd12);
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        check("b2b_first_at", 64'(first_done), 64'd8);
        check("b2b_spacing", 64'(second_done - first_done), 64'd9);
        repeat (12) @(negedge clock);

        // Randomised against the arithmetic reference.
        for (int i = 0; i < 150; i++) begin
            logic [7:0] a, b;
            logic       s;
            a = 8'($urandom);
            b = 8'($urandom);
            s = 1'($urandom);
            if (i % 10 == 0) a = 8'h80;
            if (i % 10 == 1) b = 8'h00;
            m = model(a, b, s);
            do_op(a, b, s, r, o, lat, busy_n);
            check($sformatf("rnd%0d_result a=%0h b=%0h s=%0b", i, a, b, s), {48'b0, r}, {48'b0, m[15:0]});
            check($sformatf("rnd%0d_ovf a=%0h b=%0h s=%0b", i, a, b, s), {63'b0, o}, {63'b0, m[16]});
        end

        // WIDTH=16 signed -32768 * -1.
        multiplier16 = 16'h8000; multiplicand16 = 16'hFFFF; signed_mode16 = 1'b1; start16 = 1'b1;
        @(negedge clock);
        start16 = 1'b0;
        n = 0;
        while (!done16 && n < 60) begin
            @(negedge clock);
            n++;
        end
        check("w16_done_at", 64'(n), 64'd16);
        check("w16_result", {32'b0, result16}, 64'h0000_8000);
        check("w16_ovf", {63'b0, ovf16}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
